// File: rtl/mcs6530_pkg.sv
// Shared types and constants for the mcs6530 bus arbiter: FSM states,
// requester id and the values the CPU-side bus rests at between cycles.
package mcs6530_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_WAIT   = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    // 0 = requester r0, 1 = requester r1
    typedef logic req_id_t;

    localparam logic [9:0] BUS_ADDR_IDLE = 10'h000;
    localparam logic       BUS_RS0_IDLE  = 1'b0;
    localparam logic       BUS_WE_N_IDLE = 1'b1;
    localparam logic [7:0] BUS_DI_IDLE   = 8'h00;
    localparam logic       BUS_CS_IDLE   = 1'b0;

    localparam int READ_LAT_MAX = 3;

endpackage

// File: rtl/rr_arb2.sv
// Two-way request picker. Ties go to r0 (FAIR=0) or to the requester not
// granted last (FAIR=1); the last-grant record only moves when enabled.
module rr_arb2
    import mcs6530_pkg::*;
#(
    parameter bit FAIR = 1'b1
) (
    input  logic    phi2,
    input  logic    rst,
    input  logic    en,
    input  logic    req0,
    input  logic    req1,
    output req_id_t pick,
    output logic    valid
);

    req_id_t last_grant_reg;

    assign valid = req0 | req1;

    always_comb begin
        pick = 1'b0;
        if (req0 && req1) begin
            pick = FAIR ? ~last_grant_reg : 1'b0;
        end else if (req1) begin
            pick = 1'b1;
        end
    end

    // Resetting to r1 makes r0 the winner of the first tie.
    always_ff @(posedge phi2 or posedge rst) begin
        if (rst) begin
            last_grant_reg <= 1'b1;
        end else if (en && valid) begin
            last_grant_reg <= pick;
        end
    end

endmodule

// File: rtl/mcs6530_bus_arb.sv
// Serialises two requesters onto the single mcs6530 CPU port as
// IDLE -> ACCESS -> [WAIT] -> DONE bus cycles with registered outputs.
module mcs6530_bus_arb
    import mcs6530_pkg::*;
#(
    parameter int READ_LAT = 1,
    parameter bit FAIR     = 1'b1
) (
    input  logic        phi2,
    input  logic        rst,
    input  logic        r0_req,
    input  logic        r0_we,
    input  logic [10:0] r0_addr,
    input  logic [7:0]  r0_wdata,
    output logic        r0_ack,
    output logic [7:0]  r0_rdata,
    input  logic        r1_req,
    input  logic        r1_we,
    input  logic [10:0] r1_addr,
    input  logic [7:0]  r1_wdata,
    output logic        r1_ack,
    output logic [7:0]  r1_rdata,
    output logic [9:0]  bus_addr,
    output logic        bus_rs0,
    output logic        bus_we_n,
    output logic [7:0]  bus_di,
    input  logic [7:0]  bus_do,
    output logic        bus_cs,
    output logic        busy,
    output logic        grant
);

    localparam logic [1:0] WAIT_LOAD = (READ_LAT > 0) ? 2'(READ_LAT - 1) : 2'd0;
    localparam bit         NO_WAIT   = (READ_LAT == 0);

    state_t          state_reg, state_next;
    logic            we_reg, we_next;
    logic [1:0]      cnt_reg, cnt_next;
    req_id_t         grant_reg, grant_next;
    logic            busy_reg, busy_next;
    logic [9:0]      bus_addr_reg, bus_addr_next;
    logic            bus_rs0_reg, bus_rs0_next;
    logic            bus_we_n_reg, bus_we_n_next;
    logic [7:0]      bus_di_reg, bus_di_next;
    logic            bus_cs_reg, bus_cs_next;
    logic [1:0]      ack_reg, ack_next;
    logic [1:0][7:0] rdata_reg, rdata_next;

    req_id_t     arb_pick;
    logic        arb_valid;
    logic        sel_we;
    logic [10:0] sel_addr;
    logic [7:0]  sel_wdata;
    logic        capture;
    logic        finish;

    rr_arb2 #(
        .FAIR (FAIR)
    ) u_arb (
        .phi2  (phi2),
        .rst   (rst),
        .en    (state_reg == ST_IDLE),
        .req0  (r0_req),
        .req1  (r1_req),
        .pick  (arb_pick),
        .valid (arb_valid)
    );

    assign sel_we    = arb_pick ? r1_we    : r0_we;
    assign sel_addr  = arb_pick ? r1_addr  : r0_addr;
    assign sel_wdata = arb_pick ? r1_wdata : r0_wdata;

    always_comb begin
        state_next    = state_reg;
        we_next       = we_reg;
        cnt_next      = cnt_reg;
        grant_next    = grant_reg;
        bus_addr_next = bus_addr_reg;
        bus_rs0_next  = bus_rs0_reg;
        bus_we_n_next = bus_we_n_reg;
        bus_di_next   = bus_di_reg;
        bus_cs_next   = bus_cs_reg;
        ack_next      = 2'b00;
        rdata_next    = rdata_reg;
        capture       = 1'b0;
        finish        = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (arb_valid) begin
                    state_next    = ST_ACCESS;
                    grant_next    = arb_pick;
                    we_next       = sel_we;
                    bus_addr_next = sel_addr[9:0];
                    bus_rs0_next  = sel_addr[10];
                    bus_we_n_next = ~sel_we;
                    bus_di_next   = sel_we ? sel_wdata : 8'h00;
                    bus_cs_next   = 1'b1;
                end
            end
            ST_ACCESS: begin
                if (we_reg || NO_WAIT) begin
                    finish  = 1'b1;
                    capture = ~we_reg;
                end else begin
                    state_next = ST_WAIT;
                    cnt_next   = WAIT_LOAD;
                end
            end
            ST_WAIT: begin
                if (cnt_reg == 2'd0) begin
                    finish  = 1'b1;
                    capture = 1'b1;
                end else begin
                    cnt_next = cnt_reg - 2'd1;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        // Ack and rdata are registered on the edge that enters DONE, so both
        // are visible together during the DONE cycle.
        if (finish) begin
            state_next          = ST_DONE;
            ack_next[grant_reg] = 1'b1;
            bus_addr_next       = BUS_ADDR_IDLE;
            bus_rs0_next        = BUS_RS0_IDLE;
            bus_we_n_next       = BUS_WE_N_IDLE;
            bus_di_next         = BUS_DI_IDLE;
            bus_cs_next         = BUS_CS_IDLE;
        end
        if (capture) begin
            rdata_next[grant_reg] = bus_do;
        end

        busy_next = (state_next != ST_IDLE);
    end

    always_ff @(posedge phi2 or posedge rst) begin
        if (rst) begin
            state_reg    <= ST_IDLE;
            we_reg       <= 1'b0;
            cnt_reg      <= 2'd0;
            grant_reg    <= 1'b0;
            busy_reg     <= 1'b0;
            bus_addr_reg <= BUS_ADDR_IDLE;
            bus_rs0_reg  <= BUS_RS0_IDLE;
            bus_we_n_reg <= BUS_WE_N_IDLE;
            bus_di_reg   <= BUS_DI_IDLE;
            bus_cs_reg   <= BUS_CS_IDLE;
            ack_reg      <= 2'b00;
            rdata_reg    <= '0;
        end else begin
            state_reg    <= state_next;
            we_reg       <= we_next;
            cnt_reg      <= cnt_next;
            grant_reg    <= grant_next;
            busy_reg     <= busy_next;
            bus_addr_reg <= bus_addr_next;
            bus_rs0_reg  <= bus_rs0_next;
            bus_we_n_reg <= bus_we_n_next;
            bus_di_reg   <= bus_di_next;
            bus_cs_reg   <= bus_cs_next;
            ack_reg      <= ack_next;
            rdata_reg    <= rdata_next;
        end
    end

    assign r0_ack   = ack_reg[0];
    assign r1_ack   = ack_reg[1];
    assign r0_rdata = rdata_reg[0];
    assign r1_rdata = rdata_reg[1];
    assign bus_addr = bus_addr_reg;
    assign bus_rs0  = bus_rs0_reg;
    assign bus_we_n = bus_we_n_reg;
    assign bus_di   = bus_di_reg;
    assign bus_cs   = bus_cs_reg;
    assign busy     = busy_reg;
    assign grant    = grant_reg;

endmodule

// File: tb/tb_mcs6530_bus_arb.sv
// Directed bench for mcs6530_bus_arb: one round-robin DUT with READ_LAT=2 and
// one fixed-priority DUT with READ_LAT=0 sharing the requester data inputs.
module tb_mcs6530_bus_arb;

    logic        phi2 = 1'b0;
    logic        rst  = 1'b1;
    logic        r0_req = 1'b0, r1_req = 1'b0, f0_req = 1'b0, f1_req = 1'b0;
    logic        r0_we = 1'b0, r1_we = 1'b0;
    logic [10:0] r0_addr = '0, r1_addr = '0;
    logic [7:0]  r0_wdata = '0, r1_wdata = '0;
    logic [7:0]  bus_do = '0;

    logic        r0_ack, r1_ack, bus_rs0, bus_we_n, bus_cs, busy, grant;
    logic [7:0]  r0_rdata, r1_rdata, bus_di;
    logic [9:0]  bus_addr;
    logic        fp_r0_ack, fp_r1_ack, fp_bus_rs0, fp_bus_we_n, fp_bus_cs, fp_busy, fp_grant;
    logic [7:0]  fp_r0_rdata, fp_r1_rdata, fp_bus_di;
    logic [9:0]  fp_bus_addr;

    int vectors = 0;
    int miscompares = 0;
    int n_ack0 = 0, n_ack1 = 0;
    int who;

    always #5 phi2 = ~phi2;

    mcs6530_bus_arb #(.READ_LAT(2), .FAIR(1'b1)) dut (
        .phi2(phi2), .rst(rst),
        .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
        .r0_ack(r0_ack), .r0_rdata(r0_rdata),
        .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
        .r1_ack(r1_ack), .r1_rdata(r1_rdata),
        .bus_addr(bus_addr), .bus_rs0(bus_rs0), .bus_we_n(bus_we_n), .bus_di(bus_di),
        .bus_do(bus_do), .bus_cs(bus_cs), .busy(busy), .grant(grant)
    );

    mcs6530_bus_arb #(.READ_LAT(0), .FAIR(1'b0)) dut_fp (
        .phi2(phi2), .rst(rst),
        .r0_req(f0_req), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
        .r0_ack(fp_r0_ack), .r0_rdata(fp_r0_rdata),
        .r1_req(f1_req), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
        .r1_ack(fp_r1_ack), .r1_rdata(fp_r1_rdata),
        .bus_addr(fp_bus_addr), .bus_rs0(fp_bus_rs0), .bus_we_n(fp_bus_we_n), .bus_di(fp_bus_di),
        .bus_do(bus_do), .bus_cs(fp_bus_cs), .busy(fp_busy), .grant(fp_grant)
    );

    always @(negedge phi2) begin
        if (r0_ack) n_ack0++;
        if (r1_ack) n_ack1++;
    end

    task automatic tick();
        @(posedge phi2);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Advance until some ack is seen on the chosen DUT; returns while still in the ack cycle.
    task automatic wait_any_ack(input bit fp, output int id);
        id = -1;
        for (int i = 0; i < 12 && id < 0; i++) begin
            tick();
            if (fp) begin
                if (fp_r0_ack) id = 0; else if (fp_r1_ack) id = 1;
            end else begin
                if (r0_ack) id = 0; else if (r1_ack) id = 1;
            end
        end
        chk("ack_seen", 32'(id >= 0), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // Reset state
        tick(); tick();
        chk("rst_bus", {bus_addr, bus_rs0, bus_we_n, bus_di, bus_cs}, {10'h000, 1'b0, 1'b1, 8'h00, 1'b0});
        chk("rst_ack", {r0_ack, r1_ack}, 2'b00);
        chk("rst_rdata", {r0_rdata, r1_rdata}, 16'h0000);
        chk("rst_busy_grant", {busy, grant}, 2'b00);
        rst = 1'b0;
        tick();

        // Single write from r0
        r0_we = 1'b1; r0_addr = 11'h07F; r0_wdata = 8'hA5; r0_req = 1'b1;
        tick();
        chk("w1_cs", bus_cs, 1);
        chk("w1_we_n", bus_we_n, 0);
        chk("w1_di", bus_di, 8'hA5);
        chk("w1_addr", {bus_rs0, bus_addr}, 11'h07F);
        chk("w1_busy_grant", {busy, grant}, 2'b10);
        chk("w1_ack_early", r0_ack, 0);
        tick();
        chk("w1_ack", {r0_ack, r1_ack}, 2'b10);
        chk("w1_bus_idle", {bus_cs, bus_we_n}, 2'b01);
        r0_req = 1'b0;
        tick();
        chk("w1_ack_clear", {r0_ack, busy}, 2'b00);
        tick(); tick();
        chk("w1_no_reissue", bus_cs, 0);
        chk("w1_acks", {n_ack0[7:0], n_ack1[7:0]}, {8'd1, 8'd0});
        $display("txn write r0 addr=07F data=A5");

        // Read from r1, READ_LAT=2: bus_do valid only in the sampling cycle
        r1_we = 1'b0; r1_addr = 11'h402; bus_do = 8'h11; r1_req = 1'b1;
        tick();
        chk("r1_addr", {bus_rs0, bus_addr}, 11'h402);
        chk("r1_bus", {bus_cs, bus_we_n, bus_di}, {1'b1, 1'b1, 8'h00});
        chk("r1_grant", grant, 1);
        tick();
        chk("r1_wait1", {bus_cs, r1_ack}, 2'b10);
        tick();
        chk("r1_wait2", {bus_cs, r1_ack}, 2'b10);
        bus_do = 8'h3C;
        tick();
        chk("r1_ack", {r1_ack, r0_ack}, 2'b10);
        chk("r1_rdata", r1_rdata, 8'h3C);
        chk("r1_cs_off", bus_cs, 0);
        chk("r1_r0_rdata", r0_rdata, 8'h00);
        bus_do = 8'h99; r1_req = 1'b0;
        tick();
        chk("r1_rdata_hold", {r1_ack, r1_rdata}, {1'b0, 8'h3C});
        tick();
        $display("txn read r1 addr=402 data=3C");

        // Tie with FAIR=1: expected order r0, r1, r0, r1
        r0_we = 1'b1; r0_addr = 11'h010; r0_wdata = 8'h01;
        r1_we = 1'b1; r1_addr = 11'h020; r1_wdata = 8'h02;
        r0_req = 1'b1; r1_req = 1'b1;
        for (int k = 0; k < 4; k++) begin
            wait_any_ack(1'b0, who);
            chk("tie_rr_who", who, k % 2);
            chk("tie_rr_grant", grant, k % 2);
            if (k == 3) begin
                r0_req = 1'b0; r1_req = 1'b0;
            end
            $display("txn tie round-robin write by r%0d", who);
        end
        tick(); tick(); tick();
        chk("tie_rr_cs", bus_cs, 0);
        chk("tie_rr_acks", {n_ack0[7:0], n_ack1[7:0]}, {8'd3, 8'd3});

        // Tie with FAIR=0: r0 wins until it drops req
        f0_req = 1'b1; f1_req = 1'b1;
        for (int k = 0; k < 4; k++) begin
            wait_any_ack(1'b1, who);
            chk("tie_fp_who", who, (k < 3) ? 0 : 1);
            chk("tie_fp_grant", fp_grant, (k < 3) ? 0 : 1);
            if (k == 2) f0_req = 1'b0;
            if (k == 3) f1_req = 1'b0;
            $display("txn tie fixed-priority write by r%0d", who);
        end
        tick(); tick();

        // READ_LAT=0 read on the fixed-priority DUT: sampled at end of ACCESS
        r0_we = 1'b0; r0_addr = 11'h033; bus_do = 8'h00; f0_req = 1'b1;
        tick();
        chk("lat0_cs", fp_bus_cs, 1);
        bus_do = 8'hC3;
        tick();
        chk("lat0_ack", fp_r0_ack, 1);
        chk("lat0_rdata", fp_r0_rdata, 8'hC3);
        f0_req = 1'b0; bus_do = 8'h00;
        tick(); tick();
        $display("txn read lat0 r0 addr=033 data=C3");

        // Withdrawal: r1 pulses req for one cycle while r0 read is in WAIT
        r0_we = 1'b0; r0_addr = 11'h010; r0_req = 1'b1;
        tick();
        tick();
        r1_req = 1'b1;
        tick();
        r1_req = 1'b0; bus_do = 8'h5A;
        tick();
        chk("wd_ack", {r0_ack, r1_ack}, 2'b10);
        chk("wd_rdata", r0_rdata, 8'h5A);
        chk("wd_r1_rdata", r1_rdata, 8'h3C);
        r0_req = 1'b0; bus_do = 8'h00;
        tick();
        chk("wd_cs_a", bus_cs, 0);
        tick();
        chk("wd_cs_b", bus_cs, 0);
        tick();
        chk("wd_acks", {n_ack0[7:0], n_ack1[7:0]}, {8'd4, 8'd3});
        $display("txn read r0 addr=010 data=5A with r1 withdrawal");

        // Async reset in WAIT
        r0_addr = 11'h044; r0_req = 1'b1;
        tick();
        tick();
        #1 rst = 1'b1;
        #2;
        chk("ar_bus", {bus_addr, bus_rs0, bus_we_n, bus_di, bus_cs}, {10'h000, 1'b0, 1'b1, 8'h00, 1'b0});
        chk("ar_busy_grant", {busy, grant}, 2'b00);
        chk("ar_rdata", {r0_rdata, r1_rdata}, 16'h0000);
        rst = 1'b0; r0_req = 1'b0;
        tick(); tick(); tick(); tick();
        chk("ar_no_ack", {n_ack0[7:0], n_ack1[7:0]}, {8'd4, 8'd3});
        $display("txn read r0 addr=044 aborted by reset");

        // After reset the last-grant is r1 again, so r0 takes the tie
        r0_we = 1'b1; r0_addr = 11'h111; r0_wdata = 8'h5C;
        r1_we = 1'b1; r1_addr = 11'h555; r1_wdata = 8'h77;
        r0_req = 1'b1; r1_req = 1'b1;
        wait_any_ack(1'b0, who);
        chk("pr_first", who, 0);
        r0_req = 1'b0;
        tick();
        tick();
        chk("pr_r1_addr", {bus_rs0, bus_addr}, 11'h555);
        chk("pr_r1_bus", {bus_cs, bus_we_n, bus_di, grant}, {1'b1, 1'b0, 8'h77, 1'b1});
        tick();
        chk("pr_r1_ack", r1_ack, 1);
        r1_req = 1'b0;
        tick(); tick();
        $display("txn post-reset writes r0 then r1 addr=555 data=77");

        // Back-to-back writes from r0 with new addr/data after the first ack
        r0_addr = 11'h001; r0_wdata = 8'h11; r0_req = 1'b1;
        tick();
        chk("bb_first", {bus_cs, bus_addr, bus_di}, {1'b1, 10'h001, 8'h11});
        tick();
        chk("bb_ack1", r0_ack, 1);
        r0_addr = 11'h002; r0_wdata = 8'h22;
        tick();
        chk("bb_gap", {bus_cs, r0_ack}, 2'b00);
        tick();
        chk("bb_second", {bus_cs, bus_addr, bus_di}, {1'b1, 10'h002, 8'h22});
        tick();
        chk("bb_ack2", r0_ack, 1);
        r0_req = 1'b0;
        tick(); tick();
        chk("bb_cs_off", bus_cs, 0);
        tick();
        chk("bb_acks", {n_ack0[7:0], n_ack1[7:0]}, {8'd7, 8'd4});
        $display("txn back-to-back writes r0 addr=001/002");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mcs6530_bus_arb.md
# mcs6530_bus_arb

Two-requester bus arbiter and cycle sequencer for the mcs6530 RRIOT core. It shares the core's single CPU-side port (address, RS0, write strobe, data in/out, chip select) between two clients, for example a host CPU model and a debug/test-vector port. It serialises their transactions into well-formed bus cycles and returns read data through a req/ack handshake. It sits directly above the mcs6530 instance in the sim top and replaces direct pin driving of A/DB/R_W.

## Interface
- READ_LAT, 1: phi2 cycles between the ACCESS cycle and read-data capture; legal range 0..3.
- FAIR, 1: 1 selects round-robin between requesters; 0 selects fixed priority, with r0 always winning.

- phi2  in  1  sole clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- r0_req / r1_req  in  1  transaction request, level, held until ack.
- r0_we / r1_we  in  1  1 = write, 0 = read; stable while req is high.
- r0_addr / r1_addr  in  11  bit 10 drives RS0; bits 9:0 drive A; stable while req is high.
- r0_wdata / r1_wdata  in  8  write data; stable while req is high.
- r0_ack / r1_ack  out  1  one-cycle completion pulse.
- r0_rdata / r1_rdata  out  8  read data; valid in the ack cycle, then held.
- bus_addr  out  10  to mcs6530 A.
- bus_rs0  out  1  to mcs6530 RS0.
- bus_we_n  out  1  to mcs6530 we_n; active-low write.
- bus_di  out  8  to mcs6530 DI.
- bus_do  in  8  from mcs6530 DO.
- bus_cs  out  1  chip select, high during ACCESS and WAIT.
- busy  out  1  high in every state except IDLE.
- grant  out  1  id of the requester owning the current or last transaction.

## Operation
- The FSM has four states: IDLE, ACCESS, WAIT and DONE.
- IDLE
  - If any req is high, the arbiter picks a winner, latches that requester's we/addr/wdata and sets grant. Next state is ACCESS.
  - Otherwise the FSM stays in IDLE.
- ACCESS
  - Drives bus_addr and bus_rs0 from the latch, bus_we_n = !we, bus_di = wdata (reads drive 0), bus_cs = 1.
  - For a write, next state is DONE.
  - For a read with READ_LAT = 0, bus_do is captured and next state is DONE.
  - For a read with READ_LAT > 0, next state is WAIT.
- WAIT
  - Bus outputs are held unchanged.
  - A down-counter is loaded with READ_LAT-1 on entry.
  - When the counter reaches 0, bus_do is captured into the winner's rdata and next state is DONE.
- DONE
  - Pulses the winner's ack.
  - Bus returns to idle values: addr 0, rs0 0, we_n 1, di 0, cs 0.
  - Next state is always IDLE.
- Arbitration
  - FAIR = 1: on simultaneous requests, the requester not granted last wins. The last-grant register resets to 1, so r0 wins the first tie.
  - A lone request always wins.
  - FAIR = 0: r0 wins every tie.
- Handshake rules
  - Dropping req before it is granted is a legal withdrawal; no bus cycle occurs.
  - Dropping req after grant is a protocol violation. The cycle still completes and ack still pulses.
  - A req still high in IDLE after an ack is treated as a new transaction.
- The non-winning requester's rdata and ack are never disturbed.

## Timing
- Reset values
  - bus_addr 0, bus_rs0 0, bus_we_n 1, bus_di 0, bus_cs 0.
  - r0_ack and r1_ack 0; r0_rdata and r1_rdata 0.
  - busy 0, grant 0, last-grant 1, state IDLE.
- rst asserted mid-transaction aborts it immediately: no ack, bus idle, rdata cleared.
- Write latency: req sampled in IDLE at cycle 0, ACCESS in cycle 1, ack in cycle 2.
- Read latency: ACCESS in cycle 1, WAIT in cycles 2..1+READ_LAT, bus_do sampled at the end of cycle 1+READ_LAT, ack in cycle 2+READ_LAT.
- Minimum spacing is 3 cycles per write and 3+READ_LAT cycles per read, because DONE always returns to IDLE.
- A requester that deasserts req on the edge after it sees ack is not re-issued.
- All outputs are registered; there is no combinational path from req to bus or from bus_do to rdata.

## Structure
- Package mcs6530_pkg holds:
  - the state enum (IDLE/ACCESS/WAIT/DONE);
  - the requester-id type;
  - the bus idle constants (addr 0, we_n 1, cs 0);
  - the READ_LAT maximum of 3.
- One sub-module, rr_arb2: a two-way picker with FAIR behaviour and a last-grant register, enabled only in IDLE.

## Test plan
- Single write: r0 writes 0xA5 to addr 0x07F (rs0 = 0) -> bus_cs and bus_we_n = 0 for exactly one cycle with bus_di = 0xA5, r0_ack in cycle 2, r1_ack never.
- Read with READ_LAT = 2: model returns 0x3C on bus_do for r1 at addr 0x402 -> bus_rs0 = 1, bus_addr = 0x002, cs high for 3 cycles, r1_rdata = 0x3C with r1_ack in cycle 4.
- Tie, FAIR = 1: both reqs held high for four transactions -> grant order r0, r1, r0, r1. Same stimulus with FAIR = 0 -> r0 every time until r0 drops req.
- Withdrawal: r1_req pulses for one cycle while a r0 read is in WAIT -> no r1 bus cycle and no r1_ack.
- Async reset in WAIT: rst pulsed mid-read -> all outputs return to reset values within the same cycle and no ack is issued; the next request runs normally.
- Back-to-back: r0 keeps req high across its ack with new addr/data -> a second distinct ACCESS starts 3 cycles after the first, and neither transaction is duplicated.
